// File: rtl/kypd_pkg.sv
// Shared definitions for the Pmod KYPD emulator and decoder: key map tables,
// FSM encoding and the idle column pattern.
package kypd_pkg;

  localparam logic [3:0] COL_IDLE = 4'hF;

  // Entry k is the column (c) / row (r) index of hex key k; row r0 is the top row.
  localparam logic [15:0][1:0] KEY_COL = {
    2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1,
    2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0
  };
  localparam logic [15:0][1:0] KEY_ROW = {
    2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2,
    2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } kypd_state_e;

endpackage

// File: rtl/kypd_emulator_if.sv
// Command channel into the keypad emulator: one {key, hold} press per handshake.
interface kypd_emulator_if #(
  parameter int HOLD_W = 24
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/kypd_cmd_fifo.sv
// Synchronous FIFO for queued key presses; push and pop are gated by full/empty
// internally, so a simultaneous push and pop is always safe.
module kypd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // The extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/kypd_emulator.sv
// Pmod KYPD responder: pops queued presses and drives the row lines as a closed
// switch would, against the scanner's synchronized column strobes.
module kypd_emulator
  import kypd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_W      = 24,
  parameter int GAP_CYCLES  = 65536,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  kypd_emulator_if.slave       cmd,
  input  logic [3:0]           col_in,
  output logic [3:0]           row_out,
  output logic                 busy,
  output logic                 key_active,
  output logic [3:0]           pressed_key,
  output logic                 done
);
  localparam int EW = 4 + HOLD_W;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0] fifo_dout;
  logic [3:0]    fifo_key;
  logic [HOLD_W-1:0] fifo_hold;

  kypd_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        key_q, key_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [3:0]        row_q, row_d;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]        col_s;

  kypd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd.cmd_valid),
    .din_i   ({cmd.cmd_key, cmd.cmd_hold}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign fifo_key      = fifo_dout[EW-1 -: 4];
  assign fifo_hold     = fifo_dout[HOLD_W-1:0];
  assign col_s         = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    key_d    = key_q;
    active_d = active_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          key_d    = fifo_key;
          hold_d   = (fifo_hold == '0) ? HOLD_W'(1) : fifo_hold;
          active_d = 1'b1;
          state_d  = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (hold_q == HOLD_W'(1)) begin
          active_d = 1'b0;
          gap_d    = GW'(GAP_CYCLES);
          state_d  = ST_GAP;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A low strobe on the key's column closes the switch onto its row, whatever else is low.
  always_comb begin
    row_d = COL_IDLE;
    if (active_q && !col_s[~KEY_COL[key_q]]) row_d[~KEY_ROW[key_q]] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      gap_q    <= '0;
      key_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      row_q    <= COL_IDLE;
      sync_q   <= {SYNC_STAGES{COL_IDLE}};
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      key_q    <= key_d;
      active_q <= active_d;
      done_q   <= done_d;
      row_q    <= row_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], col_in};
    end
  end

  assign row_out     = row_q;
  assign key_active  = active_q;
  assign pressed_key = key_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_kypd_emulator.sv
// Directed self-checking bench for kypd_emulator with a small scanner/decoder model.
module tb_kypd_emulator;
  localparam int HOLD_W = 24;
  localparam int GAP    = 16;

  // Hand-written key map indexed by {col, row}, independent of the package tables.
  localparam logic [15:0][3:0] KMAP = {
    4'hD, 4'hC, 4'hB, 4'hA, 4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2, 4'h0, 4'h7, 4'h4, 4'h1
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       busy, key_active, done;
  logic [3:0] pressed_key;

  int n_checks = 0;
  int n_fail   = 0;

  kypd_emulator_if #(.HOLD_W(HOLD_W)) cmd_if ();

  kypd_emulator #(
    .FIFO_DEPTH (4),
    .HOLD_W     (HOLD_W),
    .GAP_CYCLES (GAP),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if.slave),
    .col_in     (col_in),
    .row_out    (row_out),
    .busy       (busy),
    .key_active (key_active),
    .pressed_key(pressed_key),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] col_pat(input int c);
    col_pat = ~(4'b1000 >> c);
  endfunction

  task automatic push(input logic [3:0] k, input logic [HOLD_W-1:0] h);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key   = k;
    cmd_if.cmd_hold  = h;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  logic [3:0] t3_keys [4] = '{4'h1, 4'hF, 4'hA, 4'h0};
  logic [3:0] seen_q [$];

  initial begin
    int active_cnt, done_cnt, last_active, done_at, row_seen, rr;
    logic [4:0] last_key;
    logic [3:0] k;

    rst = 1'b1;
    col_in = 4'hF;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key   = '0;
    cmd_if.cmd_hold  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state, then idle column rotation
    check("rst_row", row_out, 4'hF);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_active", key_active, 0);
    check("rst_pkey", pressed_key, 0);
    check("rst_done", done, 0);
    for (int c = 0; c < 4; c++) begin
      col_in = col_pat(c);
      repeat (4) @(negedge clk);
      check("idle_row", row_out, 4'hF);
    end
    check("idle_busy", busy, 0);
    col_in = 4'hF;

    // 2: key 5, hold 100, rotating scanner
    push(4'h5, 24'd100);
    active_cnt = 0; done_cnt = 0; last_active = -1; done_at = -1;
    for (int i = 0; i < 140; i++) begin
      if (key_active) begin active_cnt++; last_active = i; end
      if (done) begin done_cnt++; done_at = i; end
      if (i % 8 == 7)
        check("t2_row", row_out,
              (i < 100 && col_pat((i / 8) % 4) == 4'b1011) ? 4'b1011 : 4'hF);
      col_in = col_pat((i / 8) % 4);
      @(negedge clk);
    end
    check("t2_active_cycles", active_cnt, 100);
    check("t2_done_count", done_cnt, 1);
    check("t2_gap_to_done", done_at - last_active, GAP + 1);
    check("t2_pkey", pressed_key, 4'h5);
    check("t2_busy_end", busy, 0);

    // 5: all columns low during key 9, then column release latency
    col_in = 4'b0000;
    push(4'h9, 24'd40);
    repeat (4) @(negedge clk);
    check("t5_row_all_cols", row_out, 4'b1101);
    col_in = 4'hF;
    repeat (2) @(negedge clk);
    check("t5_latency_2", row_out, 4'b1101);
    @(negedge clk);
    check("t5_latency_3", row_out, 4'hF);

    // 3: fill FIFO back-to-back while key 9 is still held
    for (int j = 0; j < 4; j++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = t3_keys[j];
      cmd_if.cmd_hold  = 24'd48;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    check("t3_full_ready", cmd_if.cmd_ready, 0);
    check("t3_full_busy", busy, 1);
    for (int i = 0; i < 200 && !cmd_if.cmd_ready; i++) @(negedge clk);
    check("t3_ready_back", cmd_if.cmd_ready, 1);
    check("t3_first_pop_key", pressed_key, 4'h1);
    check("t3_first_pop_active", key_active, 1);
    last_key = 5'h10;
    for (int i = 0; i < 3000; i++) begin
      if (i > 8 && !busy) break;
      if (i % 8 == 7 && row_out != 4'hF) begin
        rr = 0;
        for (int r = 0; r < 4; r++) if (!row_out[3-r]) rr = r;
        k = KMAP[((i / 8) % 4) * 4 + rr];
        if ({1'b0, k} != last_key) begin
          seen_q.push_back(k);
          last_key = {1'b0, k};
        end
      end
      col_in = col_pat((i / 8) % 4);
      @(negedge clk);
    end
    check("t3_drained", busy, 0);
    check("t3_decoded_count", seen_q.size(), 4);
    for (int j = 0; j < 4; j++)
      check("t3_decoded_key", (j < seen_q.size()) ? {1'b0, seen_q[j]} : 5'h1F, {1'b0, t3_keys[j]});

    // 4: hold=0 on key D with column 3 strobed steadily
    col_in = 4'b1110;
    repeat (3) @(negedge clk);
    push(4'hD, 24'd0);
    active_cnt = 0; done_cnt = 0; row_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (key_active) active_cnt++;
      if (done) done_cnt++;
      if (row_out == 4'b1110) row_seen++;
      @(negedge clk);
    end
    check("t4_active_cycles", active_cnt, 1);
    check("t4_row_low", row_seen, 1);
    check("t4_done_count", done_cnt, 1);
    check("t4_busy_end", busy, 0);

    // 6: reset mid-press with two entries queued
    col_in = 4'b1101;
    push(4'h3, 24'd200);
    push(4'h4, 24'd10);
    push(4'h6, 24'd10);
    repeat (4) @(negedge clk);
    check("t6_row_pre", row_out, 4'b0111);
    check("t6_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_row_rst", row_out, 4'hF);
    check("t6_busy_rst", busy, 0);
    check("t6_active_rst", key_active, 0);
    @(negedge clk);
    rst = 1'b0;
    active_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (key_active) active_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("t6_no_press", active_cnt, 0);
    check("t6_no_done", done_cnt, 0);
    check("t6_busy_after", busy, 0);
    check("t6_ready_after", cmd_if.cmd_ready, 1);
    check("t6_row_after", row_out, 4'hF);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
